// File: rtl/dpsk_deframe.sv
// Frame extractor: hunts a serial DPSK bit stream for a sync word, then reads length and payload
// into a first-word-fall-through FIFO. Optional trailing checksum under DEFRAME_CHECKSUM_EN.
`ifndef UART_DATA_WIDTH
`define UART_DATA_WIDTH 8
`endif

module dpsk_deframe #(
  parameter int unsigned            SYNC_WIDTH = 16,
  parameter logic [SYNC_WIDTH-1:0]  SYNC_WORD  = 16'hEB90,
  parameter int unsigned            DATA_WIDTH = `UART_DATA_WIDTH,
  parameter int unsigned            FIFO_DEPTH = 16
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  demod_bit,
  input  logic                  demod_bit_vld,
  output logic [DATA_WIDTH-1:0] deframe_uart_data,
  output logic                  deframe_uart_data_vld,
  input  logic                  uart_deframe_ready,
  output logic                  sync_lock,
  output logic                  frame_err
);

  localparam int unsigned BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;

  localparam logic [BCW-1:0] BitLast = BCW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]  CntFull = CW'(FIFO_DEPTH);

  localparam logic [1:0] StHunt    = 2'd0;
  localparam logic [1:0] StLen     = 2'd1;
  localparam logic [1:0] StPayload = 2'd2;
`ifdef DEFRAME_CHECKSUM_EN
  localparam logic [1:0] StCsum    = 2'd3;
`endif

  // ---------------------------------------------------------------------------------------------
  // Bit framing and state machine
  // ---------------------------------------------------------------------------------------------
  logic [1:0]            state_q, state_d;
  logic [SYNC_WIDTH-1:0] shift_q, shift_d, shift_nxt;
  logic [DATA_WIDTH-1:0] byte_q, byte_d, byte_nxt;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] len_q, len_d;
`ifdef DEFRAME_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif
  logic                  byte_done;
  logic                  push;
  logic                  err_len;
  logic                  err_csum;
  logic                  overflow;
  logic                  frame_err_q;

  assign shift_nxt = {shift_q[SYNC_WIDTH-2:0], demod_bit};
  assign byte_nxt  = {byte_q[DATA_WIDTH-2:0], demod_bit};
  assign byte_done = demod_bit_vld && (bit_cnt_q == BitLast);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    bit_cnt_d = bit_cnt_q;
    len_d     = len_q;
`ifdef DEFRAME_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    push      = 1'b0;
    err_len   = 1'b0;
    err_csum  = 1'b0;

    if (demod_bit_vld) begin
      shift_d   = shift_nxt;
      byte_d    = byte_nxt;
      bit_cnt_d = byte_done ? '0 : bit_cnt_q + 1'b1;
    end

    case (state_q)
      StHunt: begin
        bit_cnt_d = '0;
        if (demod_bit_vld && (shift_nxt == SYNC_WORD)) begin
          state_d = StLen;
        end
      end
      StLen: begin
        if (byte_done) begin
          if (byte_nxt == '0) begin
            err_len = 1'b1;
            state_d = StHunt;
          end else begin
            len_d   = byte_nxt;
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (byte_done) begin
          push  = 1'b1;
          len_d = len_q - 1'b1;
`ifdef DEFRAME_CHECKSUM_EN
          sum_d = sum_q + byte_nxt;
          if (len_q == DATA_WIDTH'(1)) state_d = StCsum;
`else
          if (len_q == DATA_WIDTH'(1)) state_d = StHunt;
`endif
        end
      end
`ifdef DEFRAME_CHECKSUM_EN
      StCsum: begin
        if (byte_done) begin
          err_csum = (byte_nxt != sum_q);
          state_d  = StHunt;
        end
      end
`endif
      default: state_d = StHunt;
    endcase

    // Fresh bit alignment for each field; stale sync bits must not re-trigger after a frame.
    if (state_d != state_q) begin
      bit_cnt_d = '0;
      if (state_d == StHunt) begin
        shift_d = '0;
`ifdef DEFRAME_CHECKSUM_EN
        sum_d   = '0;
`endif
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHunt;
      shift_q     <= '0;
      byte_q      <= '0;
      bit_cnt_q   <= '0;
      len_q       <= '0;
`ifdef DEFRAME_CHECKSUM_EN
      sum_q       <= '0;
`endif
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      byte_q      <= byte_d;
      bit_cnt_q   <= bit_cnt_d;
      len_q       <= len_d;
`ifdef DEFRAME_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
      frame_err_q <= err_len | err_csum | overflow;
    end
  end

  assign sync_lock = (state_q != StHunt);
  assign frame_err = frame_err_q;

  // ---------------------------------------------------------------------------------------------
  // Payload FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  fifo_vld;
  logic                  pop;
  logic                  full;
  logic                  wr_en;

  assign fifo_vld = (cnt_q != '0);
  assign pop      = fifo_vld && uart_deframe_ready;
  assign full     = (cnt_q == CntFull);
  // A full FIFO still accepts a byte when the head pops on the same edge.
  assign wr_en    = push && (!full || pop);
  assign overflow = push && full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      mem[wptr_q] <= byte_nxt;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (pop)   rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  assign deframe_uart_data_vld = fifo_vld;
  assign deframe_uart_data     = fifo_vld ? mem[rptr_q] : '0;

endmodule
